// File: rtl/liang_pkg.sv
// Shared types and widths for the liang core bus fabric.
// Holds the AXI-lite response encoding, the default bus widths and the
// state encodings of the AXI-lite SRAM responder's read and write FSMs.
package liang_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Wait-state counters are 4 bits, so latencies run 0..15.
  localparam int LAT_W   = 4;
  localparam int LAT_MAX = 15;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/axi_lite_sram_array.sv
// sram_array: DEPTH x DATA_WIDTH word storage behind the AXI-lite responder.
// Ports:
//   clk_i    clock
//   we_i     write enable (one write port, byte strobed by wstrb_i)
//   waddr_i  write word index
//   wdata_i  write data
//   wstrb_i  byte strobes, bit b enables byte lane b
//   re_i     read enable; rdata_o updates on the following edge only when set
//   raddr_i  read word index
//   rdata_o  registered read data (holds between read enables)
// A read and a write to the same word on the same edge return the old word.
module sram_array #(
  parameter int DEPTH      = 4096,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/axi_lite_sram.sv
// axi_lite_sram: AXI-lite responder memory model with programmable wait states.
// Sits behind the LSU/IFU arbiter so both masters see realistic handshakes.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   araddr_i/arvalid_i/arready_o      read address channel
//   rdata_o/rresp_o/rvalid_o/rready_i read data channel
//   awaddr_i/awvalid_i/awready_o      write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o write data channel
//   bresp_o/bvalid_o/bready_i         write response channel
// Addresses decode to word index (addr - BASE_ADDR) >> 2; anything outside
// [BASE_ADDR, BASE_ADDR + 4*DEPTH) answers SLVERR without touching storage.
module axi_lite_sram #(
  parameter int                        ADDR_WIDTH    = liang_pkg::ADDR_WIDTH,
  parameter int                        DATA_WIDTH    = liang_pkg::DATA_WIDTH,
  parameter int                        STRB_WIDTH    = liang_pkg::STRB_WIDTH,
  parameter int                        DEPTH         = 4096,
  parameter logic [ADDR_WIDTH-1:0]     BASE_ADDR     = 32'h8000_0000,
  parameter int                        READ_LATENCY  = 2,
  parameter int                        WRITE_LATENCY = 2,
  parameter                            INIT_FILE     = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i
);

  import liang_pkg::*;

  localparam int                  IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN  = (ADDR_WIDTH+1)'(4 * DEPTH);

  if (READ_LATENCY < 0 || READ_LATENCY > LAT_MAX) begin : g_bad_rlat
    $error("axi_lite_sram: READ_LATENCY must be within 0..15");
  end
  if (WRITE_LATENCY < 0 || WRITE_LATENCY > LAT_MAX) begin : g_bad_wlat
    $error("axi_lite_sram: WRITE_LATENCY must be within 0..15");
  end

  // One extra bit catches addresses below BASE_ADDR as a borrow.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return !off[ADDR_WIDTH] && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  // ---------------------------------------------------------------- read side
  rd_state_e             r_state, r_state_nxt;
  logic [LAT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_src_addr;
  logic                  r_sample;
  axi_resp_e             r_resp;
  logic [DATA_WIDTH-1:0] arr_rdata;

  always_comb begin
    r_state_nxt = r_state;
    arready_o   = 1'b0;
    rvalid_o    = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready_o = 1'b1;
        if (arvalid_i) r_state_nxt = (READ_LATENCY == 0) ? R_RESP : R_WAIT;
      end
      R_WAIT: if (r_cnt == '0) r_state_nxt = R_RESP;
      R_RESP: begin
        rvalid_o = 1'b1;
        if (rready_i) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // The array is sampled on the edge that enters R_RESP; with zero latency
  // that edge is the AR handshake itself, so the live address is used.
  assign r_sample   = (r_state != R_RESP) && (r_state_nxt == R_RESP);
  assign r_src_addr = (r_state == R_IDLE) ? araddr_i : r_addr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_resp  <= RESP_OKAY;
    end else begin
      r_state <= r_state_nxt;
      if (r_state == R_IDLE && arvalid_i) r_cnt <= LAT_W'(READ_LATENCY);
      else if (r_state == R_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (r_sample) r_resp <= in_range(r_src_addr) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_state == R_IDLE && arvalid_i) r_addr <= araddr_i;
  end

  // Array output holds between samples, so gating by state keeps the beat stable.
  assign rdata_o = (r_state == R_RESP && r_resp == RESP_OKAY) ? arr_rdata : '0;
  assign rresp_o = (r_state == R_RESP) ? r_resp : RESP_OKAY;

  // --------------------------------------------------------------- write side
  wr_state_e             w_state, w_state_nxt;
  logic [LAT_W-1:0]      w_cnt;
  logic                  aw_got, w_got;
  logic                  aw_hs, w_hs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  axi_resp_e             b_resp;

  always_comb begin
    w_state_nxt = w_state;
    awready_o   = 1'b0;
    wready_o    = 1'b0;
    bvalid_o    = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        awready_o = !aw_got;
        wready_o  = !w_got;
        aw_hs     = awvalid_i && !aw_got;
        w_hs      = wvalid_i && !w_got;
        if ((aw_got || aw_hs) && (w_got || w_hs)) w_state_nxt = W_WAIT;
      end
      W_WAIT: if (w_cnt == '0) w_state_nxt = W_RESP;
      W_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign w_commit = (w_state == W_WAIT) && (w_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else begin
      w_state <= w_state_nxt;
      if (w_state == W_IDLE) begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
        if (w_state_nxt == W_WAIT) begin
          w_cnt  <= LAT_W'(WRITE_LATENCY);
          aw_got <= 1'b0;
          w_got  <= 1'b0;
        end
      end else if (w_state == W_WAIT && w_cnt != '0) begin
        w_cnt <= w_cnt - 1'b1;
      end
      if (w_commit) b_resp <= in_range(w_addr) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_hs) w_addr <= awaddr_i;
    if (w_hs) begin
      w_data <= wdata_i;
      w_strb <= wstrb_i;
    end
  end

  assign bresp_o = (w_state == W_RESP) ? b_resp : RESP_OKAY;

  // ------------------------------------------------------------------ storage
  sram_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .IDX_W      (IDX_W),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (w_commit && in_range(w_addr)),
    .waddr_i (word_idx(w_addr)),
    .wdata_i (w_data),
    .wstrb_i (w_strb),
    .re_i    (r_sample && in_range(r_src_addr)),
    .raddr_i (word_idx(r_src_addr)),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_axi_lite_sram.sv
// Bench for axi_lite_sram: directed scenarios plus randomized traffic
// checked against a word-array reference model kept in this file.
module tb_axi_lite_sram;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          RLAT  = 2;
  localparam int          WLAT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  always #5 clk = ~clk;

  axi_lite_sram #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .STRB_WIDTH    (4),
    .DEPTH         (DEPTH),
    .BASE_ADDR     (BASE),
    .READ_LATENCY  (RLAT),
    .WRITE_LATENCY (WLAT),
    .INIT_FILE     ("")
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .araddr_i  (araddr),
    .arvalid_i (arvalid),
    .arready_o (arready),
    .rdata_o   (rdata),
    .rresp_o   (rresp),
    .rvalid_o  (rvalid),
    .rready_i  (rready),
    .awaddr_i  (awaddr),
    .awvalid_i (awvalid),
    .awready_o (awready),
    .wdata_i   (wdata),
    .wstrb_i   (wstrb),
    .wvalid_i  (wvalid),
    .wready_o  (wready),
    .bresp_o   (bresp),
    .bvalid_o  (bvalid),
    .bready_i  (bready)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference memory: plain word array plus a "fully written" flag per word.
  logic [31:0] model [DEPTH];
  bit          known [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] addr);
    logic [63:0] a, lo, hi;
    a  = {32'h0, addr};
    lo = {32'h0, BASE};
    hi = lo + 64'(4 * DEPTH);
    return (a >= lo) && (a < hi);
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'((addr - BASE) / 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int t, lat, i;
    bit aw_done, w_done, hold_ok, busy_ok, a_hs, d_hs, b_stable;
    logic [1:0] eresp;
    t = 0; aw_done = 0; w_done = 0; hold_ok = 1; busy_ok = 1; b_stable = 1;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && t < 100) begin
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      if (awready !== !aw_done || wready !== !w_done) hold_ok = 0;
      a_hs = awvalid && awready;
      d_hs = wvalid && wready;
      tick();
      t++;
      if (a_hs) aw_done = 1;
      if (d_hs) w_done = 1;
    end
    awvalid = 0; wvalid = 0;
    check_eq("wr_capture", {30'h0, aw_done, w_done}, 32'h3);
    check_eq("wr_ready_hold", hold_ok, 1);
    lat = 0;
    while (!bvalid && lat < 50) begin
      if (awready || wready) busy_ok = 0;
      tick();
      lat++;
    end
    check_eq("wr_latency", lat, WLAT + 1);
    if (awready || wready) busy_ok = 0;
    check_eq("wr_busy_ready_low", busy_ok, 1);
    eresp = in_rng(addr) ? 2'b00 : 2'b10;
    check_eq("bresp", bresp, eresp);
    if (in_rng(addr)) begin
      i = widx(addr);
      for (int b = 0; b < 4; b++) if (strb[b]) model[i][8*b +: 8] = data[8*b +: 8];
      if (strb == 4'hF) known[i] = 1;
    end
    repeat (b_dly) begin
      tick();
      if (!bvalid || bresp !== eresp || awready || wready) b_stable = 0;
    end
    check_eq("b_stable", b_stable, 1);
    bready = 1;
    tick();
    bready = 0;
    check_eq("b_done_bvalid", bvalid, 0);
    check_eq("b_done_readies", {30'h0, awready, wready}, 32'h3);
  endtask

  task automatic do_read(input logic [31:0] addr, input int bp, output logic [31:0] got);
    int t, lat, i;
    bit lo_ok, stable, chk_data;
    logic [31:0] exp_d, d0;
    logic [1:0]  exp_r, r0;
    // Expectation is taken now, before any concurrent write reaches the model.
    chk_data = 1;
    if (in_rng(addr)) begin
      i = widx(addr);
      exp_d = model[i];
      exp_r = 2'b00;
      chk_data = known[i];
    end else begin
      exp_d = 32'h0;
      exp_r = 2'b10;
    end
    t = 0; lo_ok = 1; stable = 1;
    araddr = addr; arvalid = 1;
    while (!arready && t < 50) begin
      tick();
      t++;
    end
    check_eq("ar_ready", arready, 1);
    tick();
    arvalid = 0;
    lat = 0;
    while (!rvalid && lat < 50) begin
      if (arready) lo_ok = 0;
      tick();
      lat++;
    end
    check_eq("rd_latency", lat, RLAT + 1);
    if (arready) lo_ok = 0;
    check_eq("rd_busy_arready_low", lo_ok, 1);
    d0 = rdata; r0 = rresp; got = rdata;
    check_eq("rresp", rresp, exp_r);
    if (chk_data) check_eq("rdata", rdata, exp_d);
    repeat (bp) begin
      tick();
      if (!rvalid || rdata !== d0 || rresp !== r0 || arready) stable = 0;
    end
    check_eq("r_stable", stable, 1);
    rready = 1;
    tick();
    rready = 0;
    check_eq("r_done_rvalid", rvalid, 0);
    check_eq("r_done_arready", arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, a, d;
    bit stale;
    int sel;
    rst = 1; arvalid = 0; araddr = 0; rready = 0;
    awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    for (int i = 0; i < DEPTH; i++) begin model[i] = 0; known[i] = 0; end
    repeat (3) tick();
    rst = 0;
    check_eq("rst_readies", {29'h0, arready, awready, wready}, 32'h7);
    check_eq("rst_valids", {30'h0, rvalid, bvalid}, 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_resps", {28'h0, rresp, bresp}, 32'h0);

    // Preload the words the rest of the run touches.
    for (int i = 0; i < 16; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);
    for (int i = DEPTH - 16; i < DEPTH; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);

    // Word read with known contents.
    do_write(BASE, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(BASE, 0, got);
    check_eq("word0_read", got, 32'hDEAD_BEEF);

    // Single-lane strobe into a cleared word.
    do_write(BASE + 4, 32'h0, 4'hF, 0, 0, 0);
    do_write(BASE + 4, 32'h1122_3344, 4'b0100, 0, 0, 0);
    do_read(BASE + 4, 0, got);
    check_eq("strobe_read", got, 32'h0022_0000);

    // Empty strobe leaves the word alone; AW well ahead of W, and W ahead of AW.
    do_write(BASE + 4, 32'hFFFF_FFFF, 4'b0000, 0, 5, 1);
    do_write(BASE + 8, 32'hA5A5_5A5A, 4'hF, 4, 0, 2);
    do_read(BASE + 4, 0, got);
    check_eq("nostrobe_read", got, 32'h0022_0000);

    // Backpressure on the read beat.
    do_read(BASE + 8, 4, got);
    check_eq("bp_read", got, 32'hA5A5_5A5A);

    // Out-of-range accesses, including one that would alias word 0 if truncated.
    do_read(32'h7FFF_FFFC, 2, got);
    do_write(32'h8000_4000, 32'h1234_5678, 4'hF, 0, 0, 0);
    do_read(BASE, 0, got);
    check_eq("oor_no_alias", got, 32'hDEAD_BEEF);
    do_read(BASE + 32'(4 * (DEPTH - 1)) + 3, 0, got);

    // Read and write commit on the same edge to the same word: old data returns.
    fork
      do_write(BASE + 12, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
      do_read(BASE + 12, 0, got);
    join
    do_read(BASE + 12, 0, got);
    check_eq("collide_after", got, 32'h0BAD_F00D);

    // Reset while the read is waiting drops it without a beat.
    araddr = BASE; arvalid = 1;
    tick();
    arvalid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    check_eq("midrst_rvalid", rvalid, 0);
    check_eq("midrst_arready", arready, 1);
    stale = 0;
    repeat (8) begin
      tick();
      if (rvalid) stale = 1;
    end
    check_eq("midrst_no_stale", stale, 0);
    do_read(BASE, 1, got);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      else if (sel < 8) a = BASE + 32'(4 * (DEPTH - 16 + $urandom_range(0, 15)));
      else if (sel < 9) a = BASE - 32'(4 * $urandom_range(1, 8));
      else              a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        do_read(a, $urandom_range(0, 3), got);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
